// File: rtl/frame_capture_ctrl.sv
// Receive-pass sequencer for the BEP thermostat decoder: bit-stall watchdog, frame judging,
// good/bad/timeout counters and a hold/pending double buffer feeding the host read mux.
module frame_capture_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned CNT_WIDTH      = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        transmission_begin,
   input  logic        bit_strobe,
   input  logic        frame_full,
   input  logic        frame_valid,
   input  logic [95:0] payload,
   input  logic [3:0]  rd_addr,
   input  logic        rd_hold,
   input  logic        frame_ack,
   output logic        decoder_clear,
   output logic [7:0]  rd_data,
   output logic        new_frame,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RECEIVE = 3'd1,
      CHECK   = 3'd2,
      COMMIT  = 3'd3,
      DISCARD = 3'd4,
      ABORT   = 3'd5,
      CLEAR   = 3'd6
   } state_t;

   localparam logic [15:0]          TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

   state_t               state, state_nxt;
   logic [15:0]          timer;
   logic                 timer_clr;
   logic [95:0]          front, pending;
   logic                 pend_valid;
   logic                 front_upd;
   logic [CNT_WIDTH-1:0] good_cnt, bad_cnt, tmo_cnt;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
      return (&c) ? c : c + CNT_ONE;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_nxt;
         if (timer_clr)
            timer <= '0;
         else if (state == RECEIVE)
            timer <= timer + 16'd1;
      end
   end

   // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
   always_comb begin
      state_nxt = state;
      timer_clr = 1'b0;
      unique case (state)
         IDLE: begin
            if (transmission_begin) begin
               state_nxt = RECEIVE;
               timer_clr = 1'b1;
            end
         end
         RECEIVE: begin
            // a completed frame outranks both a restart and the watchdog
            if (frame_full)
               state_nxt = CHECK;
            else if (transmission_begin || bit_strobe)
               timer_clr = 1'b1;
            else if (timer == TIMER_LAST)
               state_nxt = ABORT;
         end
         CHECK:                   state_nxt = frame_valid ? COMMIT : DISCARD;
         COMMIT, DISCARD, ABORT:  state_nxt = CLEAR;
         CLEAR:                   state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         good_cnt <= '0;
         bad_cnt  <= '0;
         tmo_cnt  <= '0;
      end else begin
         if (state == COMMIT)  good_cnt <= sat_inc(good_cnt);
         if (state == DISCARD) bad_cnt  <= sat_inc(bad_cnt);
         if (state == ABORT)   tmo_cnt  <= sat_inc(tmo_cnt);
      end
   end

   // A fresh commit and a pending swap both land in front only while the host is not holding.
   assign front_upd = !rd_hold && ((state == COMMIT) || pend_valid);

   // NOTE: the banks are reset so the host reads zeros, not stale data, after rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         front      <= '0;
         pending    <= '0;
         pend_valid <= 1'b0;
         new_frame  <= 1'b0;
      end else begin
         if (state == COMMIT && !rd_hold) begin
            front      <= payload;
            pend_valid <= 1'b0;
         end else if (state == COMMIT) begin
            pending    <= payload;
            pend_valid <= 1'b1;
         end else if (!rd_hold && pend_valid) begin
            front      <= pending;
            pend_valid <= 1'b0;
         end

         if (front_upd)
            new_frame <= 1'b1;
         else if (frame_ack)
            new_frame <= 1'b0;
      end
   end

   assign decoder_clear = (state == CLEAR);
   assign busy          = (state != IDLE);

   always_comb begin
      rd_data = 8'h00;
      unique case (rd_addr)
         4'd0:  rd_data = front[7:0];
         4'd1:  rd_data = front[15:8];
         4'd2:  rd_data = front[23:16];
         4'd3:  rd_data = front[31:24];
         4'd4:  rd_data = front[39:32];
         4'd5:  rd_data = front[47:40];
         4'd6:  rd_data = front[55:48];
         4'd7:  rd_data = front[63:56];
         4'd8:  rd_data = front[71:64];
         4'd9:  rd_data = front[87:80];
         4'd10: rd_data = front[79:72];
         4'd11: rd_data = front[95:88];
         4'd12: rd_data = 8'(good_cnt);
         4'd13: rd_data = 8'(bad_cnt);
         4'd14: rd_data = {2'b00, new_frame, pend_valid, rd_hold, state};
         4'd15: rd_data = 8'(tmo_cnt);
         default: rd_data = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl: table readback of a committed frame plus
// hand-written sequences for bad frames, stall/restart, hold swap, ack races and reset.
module tb_frame_capture_ctrl;

   localparam int unsigned TMO = 16;
   localparam int unsigned CW  = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        transmission_begin, bit_strobe, frame_full, frame_valid;
   logic [95:0] payload;
   logic [3:0]  rd_addr;
   logic        rd_hold, frame_ack;
   logic        decoder_clear;
   logic [7:0]  rd_data;
   logic        new_frame, busy;

   frame_capture_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .transmission_begin (transmission_begin),
      .bit_strobe         (bit_strobe),
      .frame_full         (frame_full),
      .frame_valid        (frame_valid),
      .payload            (payload),
      .rd_addr            (rd_addr),
      .rd_hold            (rd_hold),
      .frame_ack          (frame_ack),
      .decoder_clear      (decoder_clear),
      .rd_data            (rd_data),
      .new_frame          (new_frame),
      .busy               (busy)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int dc_count = 0;

   always @(posedge clk) if (decoder_clear === 1'b1) dc_count <= dc_count + 1;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] exp;
   } rd_vec_t;

   rd_vec_t tbl [16];

   function automatic logic [95:0] make_payload(input logic [31:0] id, input logic [15:0] room,
                                                input logic [15:0] set_t, input logic [7:0] st,
                                                input logic [7:0] t1, input logic [7:0] t2,
                                                input logic [7:0] t3);
      return {t3, t2, t1, st, set_t, room, id};
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_rd(input string name, input logic [3:0] a, input logic [7:0] exp);
      rd_addr = a;
      #1;
      check(name, {24'h0, rd_data}, {24'h0, exp});
   endtask

   task automatic check_state(input string name, input logic [2:0] exp);
      rd_addr = 4'd14;
      #1;
      check(name, {29'h0, rd_data[2:0]}, {29'h0, exp});
   endtask

   // Full pass from IDLE: begin, three strobes 10 cycles apart, then frame_full at cycle N.
   task automatic send_frame(input string tag, input logic [95:0] p, input logic v,
                             input logic ack_at_commit, input logic release_hold);
      int dc0;
      transmission_begin = 1'b1;
      tick();
      transmission_begin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(9);
         bit_strobe = 1'b1;
         tick();
         bit_strobe = 1'b0;
      end
      payload     = p;
      frame_full  = 1'b1;
      frame_valid = v;
      dc0         = dc_count;
      tick();
      check_state({tag, " CHECK at N+1"}, 3'd2);
      tick();
      check_state({tag, v ? " COMMIT at N+2" : " DISCARD at N+2"}, v ? 3'd3 : 3'd4);
      check({tag, " no clear at N+2"}, {31'h0, decoder_clear}, 32'd0);
      if (ack_at_commit) frame_ack = 1'b1;
      if (release_hold)  rd_hold   = 1'b0;
      tick();
      frame_ack   = 1'b0;
      frame_full  = 1'b0;
      frame_valid = 1'b0;
      check({tag, " decoder_clear at N+3"}, {31'h0, decoder_clear}, 32'd1);
      tick();
      check({tag, " busy low at N+4"}, {31'h0, busy}, 32'd0);
      check({tag, " one clear pulse"}, dc_count, dc0 + 1);
   endtask

   initial begin
      rst_n = 1'b0;
      transmission_begin = 1'b0;
      bit_strobe = 1'b0;
      frame_full = 1'b0;
      frame_valid = 1'b0;
      payload = '0;
      rd_addr = 4'd0;
      rd_hold = 1'b0;
      frame_ack = 1'b0;

      tbl = '{'{4'd0, 8'hEF}, '{4'd1, 8'hBE}, '{4'd2, 8'hAD}, '{4'd3, 8'hDE},
              '{4'd4, 8'hE6}, '{4'd5, 8'h00}, '{4'd6, 8'hD2}, '{4'd7, 8'h00},
              '{4'd8, 8'h01}, '{4'd9, 8'hB2}, '{4'd10, 8'hA1}, '{4'd11, 8'hC3},
              '{4'd12, 8'h01}, '{4'd13, 8'h00}, '{4'd14, 8'h20}, '{4'd15, 8'h00}};

      // reset state
      #5;
      check("reset decoder_clear", {31'h0, decoder_clear}, 32'd0);
      check("reset busy", {31'h0, busy}, 32'd0);
      check("reset new_frame", {31'h0, new_frame}, 32'd0);
      check_rd("reset addr0", 4'd0, 8'h00);
      check_rd("reset status", 4'd14, 8'h00);
      #13 rst_n = 1'b1;
      tick();

      // good frame A, then table readback of the whole map
      send_frame("frameA", make_payload(32'hDEADBEEF, 16'h00E6, 16'h00D2, 8'h01,
                                        8'hA1, 8'hB2, 8'hC3), 1'b1, 1'b0, 1'b0);
      check("frameA new_frame", {31'h0, new_frame}, 32'd1);
      for (int i = 0; i < 16; i++)
         check_rd($sformatf("frameA rd_addr %0d", tbl[i].addr), tbl[i].addr, tbl[i].exp);

      // bad frame leaves front and new_frame alone
      tick();
      send_frame("bad1", {12{8'h5A}}, 1'b0, 1'b0, 1'b0);
      check_rd("bad1 bad_cnt", 4'd13, 8'h01);
      check_rd("bad1 front kept", 4'd0, 8'hEF);
      check_rd("bad1 status", 4'd14, 8'h20);

      // stall with a restart: abort TMO cycles after the restart, not after the first begin
      tick();
      transmission_begin = 1'b1;
      tick();
      transmission_begin = 1'b0;
      tick(10);
      check_state("stall still receiving", 3'd1);
      transmission_begin = 1'b1;
      tick();
      transmission_begin = 1'b0;
      tick(TMO - 1);
      check_state("stall RECEIVE at timer last", 3'd1);
      check_rd("stall tmo before abort", 4'd15, 8'h00);
      tick();
      check_state("stall ABORT", 3'd5);
      tick();
      check("stall decoder_clear", {31'h0, decoder_clear}, 32'd1);
      tick();
      check_state("stall back to IDLE", 3'd0);
      check_rd("stall tmo_cnt", 4'd15, 8'h01);
      check_rd("stall bad_cnt kept", 4'd13, 8'h01);

      // ack alone clears new_frame
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      check_rd("ack clears new_frame", 4'd14, 8'h00);

      // hold: commit goes to pending, release swaps it in
      rd_hold = 1'b1;
      send_frame("frameB", make_payload(32'h11223344, 16'h0101, 16'h0202, 8'h02,
                                        8'h03, 8'h04, 8'h05), 1'b1, 1'b0, 1'b0);
      check_rd("hold front kept", 4'd0, 8'hEF);
      check_rd("hold status pend", 4'd14, 8'h18);
      check_rd("hold good_cnt", 4'd12, 8'h02);
      rd_hold = 1'b0;
      tick();
      check_rd("swap addr0", 4'd0, 8'h44);
      check_rd("swap addr3", 4'd3, 8'h11);
      check_rd("swap status", 4'd14, 8'h20);

      // same-cycle ack loses to the front update
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      send_frame("frameC", make_payload(32'hCAFEF00D, 16'h0010, 16'h0020, 8'h00,
                                        8'h00, 8'h00, 8'h00), 1'b1, 1'b1, 1'b0);
      check_rd("ack race status", 4'd14, 8'h20);
      check_rd("ack race addr0", 4'd0, 8'h0D);
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      check_rd("later ack clears", 4'd14, 8'h00);

      // commit with hold released in the COMMIT cycle beats the pending swap
      rd_hold = 1'b1;
      send_frame("frameD", make_payload(32'h55667788, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0),
                 1'b1, 1'b0, 1'b0);
      check_rd("frameD pending status", 4'd14, 8'h18);
      send_frame("frameE", make_payload(32'h0BADF099, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0),
                 1'b1, 1'b0, 1'b1);
      check_rd("collision front", 4'd0, 8'h99);
      check_rd("collision status", 4'd14, 8'h20);
      tick();
      check_rd("collision no late swap", 4'd0, 8'h99);
      check_rd("good_cnt saturated", 4'd12, 8'h03);

      // bad counter saturation
      for (int i = 0; i < 5; i++) send_frame("badsat", {12{8'hA5}}, 1'b0, 1'b0, 1'b0);
      check_rd("bad_cnt saturated", 4'd13, 8'h03);
      check_rd("tmo_cnt kept", 4'd15, 8'h01);

      // async reset mid-RECEIVE, away from the clock edge
      transmission_begin = 1'b1;
      tick();
      transmission_begin = 1'b0;
      tick(2);
      check_state("pre-reset RECEIVE", 3'd1);
      #4 rst_n = 1'b0;
      #1;
      check("async reset busy", {31'h0, busy}, 32'd0);
      check("async reset new_frame", {31'h0, new_frame}, 32'd0);
      check("async reset decoder_clear", {31'h0, decoder_clear}, 32'd0);
      check_rd("async reset bad_cnt", 4'd13, 8'h00);
      check_rd("async reset good_cnt", 4'd12, 8'h00);
      check_rd("async reset addr0", 4'd0, 8'h00);
      check_rd("async reset status", 4'd14, 8'h00);
      #7 rst_n = 1'b1;
      tick();
      check("post-reset idle", {31'h0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
